// File: rtl/pc_fetch_unit.sv
// PC register and next-PC selection with a BOOT/RUN/HALT sequencer.
// Optional PC_ALIGN_CHECK_EN traps misaligned jump-register targets to EXC_VECTOR.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        branch_en,
  input  logic        branch_on_ne,
  input  logic        zero,
  input  logic [15:0] branch_off,
  input  logic        jump_en,
  input  logic [25:0] jump_target,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        exc_flag
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        exc_d;
  logic [31:0] jr_tgt;
  logic        jr_trap;
  logic [31:0] jump_tgt;
  logic [31:0] branch_tgt;
  logic        branch_taken;

  assign pc_plus4     = pc_q + 32'd4;
  assign jump_tgt     = {pc_plus4[31:28], jump_target, 2'b00};
  assign branch_tgt   = pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};
  assign branch_taken = branch_en & (zero ^ branch_on_ne);

`ifdef PC_ALIGN_CHECK_EN
  logic exc_q;

  assign jr_trap = |jr_addr[1:0];
  assign jr_tgt  = jr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exc_q <= 1'b0;
    else        exc_q <= exc_d;
  end

  assign exc_flag = exc_q;
`else
  logic unused_ok;

  assign jr_trap   = 1'b0;
  assign jr_tgt    = jr_addr & ~32'd3;
  assign exc_flag  = 1'b0;
  assign unused_ok = exc_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    exc_d   = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          if (jr_en) begin
            pc_d  = jr_trap ? EXC_VECTOR : jr_tgt;
            exc_d = jr_trap;
          end else if (jump_en) begin
            pc_d = jump_tgt;
          end else if (branch_taken) begin
            pc_d = branch_tgt;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage of the single-cycle processor.
- Holds the architectural PC and presents it to instruction memory.
- Selects the next PC from sequential, branch, jump and jump-register sources.
- Consumes the zero flag produced by the ALU's OR-reduction zero-detect tree to resolve conditional branches. Adds a boot cycle, stall and halt state machine.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on a misaligned jump-register target (optional feature only).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC this cycle.
- halt_req  input  1  decoded halt instruction.
- branch_en  input  1  current instruction is a conditional branch.
- branch_on_ne  input  1  0 = branch if equal (zero=1), 1 = branch if not equal (zero=0).
- zero  input  1  ALU zero flag (NOR of ALU result bits).
- branch_off  input  16  signed word offset.
- jump_en  input  1  absolute jump.
- jump_target  input  26  word index for jump.
- jr_en  input  1  jump-register.
- jr_addr  input  32  register-sourced target.
- pc  output  32  current PC to instruction memory.
- pc_plus4  output  32  pc + 4, for link and branch base.
- fetch_valid  output  1  pc holds a fetchable instruction.
- halted  output  1  core halted.
- exc_flag  output  1  one-cycle misalignment trap pulse.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async, any state, mid-operation included): pc=RESET_PC, state=BOOT, fetch_valid=0, halted=0, exc_flag=0. Takes effect immediately, without waiting for a clock edge.
- pc_plus4 = pc + 4, combinational, modulo 2^32. PC 32'hFFFF_FFFC sequences to 32'h0000_0000.
- States: BOOT, RUN, HALT.
- BOOT:
  - First edge after rst_n deasserts moves to RUN.
  - pc unchanged; fetch_valid becomes 1 on entering RUN.
  - All control inputs ignored.
- RUN: fetch_valid=1. Each rising edge picks next_pc by priority:
  1. halt_req: go to HALT, pc held. halt_req beats stall.
  2. stall: pc held, remain RUN.
  3. jr_en: next_pc = jr_addr.
  4. jump_en: next_pc = {pc_plus4[31:28], jump_target, 2'b00}.
  5. branch taken, defined as branch_en & (zero XOR branch_on_ne): next_pc = pc_plus4 + (sign-extended branch_off << 2). The add wraps modulo 2^32.
  6. Otherwise: next_pc = pc_plus4.
- Multiple of jr_en/jump_en/branch_en asserted together: the highest priority wins, with no error.
- HALT:
  - fetch_valid=0, halted=1, pc frozen.
  - All inputs ignored; only rst_n exits HALT.
- Latency: a redirect is visible on pc one edge after the control input is sampled. There is no delay slot.
- Without the optional feature, jr_addr[1:0] is forced to 2'b00 and exc_flag is tied 0.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: in RUN, a selected jr_en with jr_addr[1:0] != 0 loads pc=EXC_VECTOR instead of jr_addr. exc_flag=1 for exactly the following cycle, then 0.
  - Misaligned jr_en while stall or halt_req is high: no trap.
- Undefined: the check logic is absent. jr_addr low bits are cleared as described in Behaviour, and the exc_flag port is present but constant 0.

Test Plan:
- Reset then release, no controls: pc=32'h0040_0000 with fetch_valid=0 for one edge. Then fetch_valid=1, pc advances 0040_0004, 0040_0008 on successive edges.
- At pc=0040_0010: branch_en=1, branch_on_ne=0, zero=1, branch_off=16'hFFFC gives pc=0040_0004. Same stimulus with zero=0 gives pc=0040_0014.
- At pc=0040_0020: jump_en=1, jump_target=26'h000_0100 and branch_en=1 (taken) together gives pc=0000_0400, the jump winning. Next cycle jr_en=1, jr_addr=0040_1000 gives pc=0040_1000.
- stall=1 for 3 edges at pc=0040_0008 keeps pc constant. halt_req=1 with stall=1 gives halted=1 and fetch_valid=0, and pc stays frozen for 10 edges. Asserting rst_n low mid-HALT immediately returns pc to 0040_0000 with halted=0.
- Force pc=FFFF_FFFC via jr: the next sequential edge gives pc=0000_0000 and pc_plus4=0000_0004.
- With PC_ALIGN_CHECK_EN: jr_addr=0040_1002 gives pc=8000_0180 and exc_flag high for exactly one cycle. Without the macro, the same stimulus gives pc=0040_1000 and exc_flag=0.
